// File: rtl/uncache_pkg.sv
// Shared encodings for the uncached data port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uncache_pkg;

  // Access size encodings carried on req_size / bus_size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/uncache_dport.sv
// Uncached MEM-stage data port: one request at a time onto an SRAM-like bus.
// Latency: accept to resp_valid is 2 cycles minimum (addr_ok and data_ok together), plus bus wait.
// Backpressure: req_ready only in IDLE; stall holds the pipeline; UNCACHE_POSTED_STORE_EN posts stores.
module uncache_dport
  import uncache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic [3:0]        req_wstrb,
  input  logic [ADDR_W-1:0] req_paddr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t state, state_nxt;

  logic              l_wen;
  logic [1:0]        l_size;
  logic [3:0]        l_wstrb;
  logic [ADDR_W-1:0] l_paddr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] rdata_q;

  logic accept;
  logic capture;

  // A request is taken only from IDLE; data completes either together with the
  // address handshake in REQ or later in WAIT. data_ok anywhere else is ignored.
  assign accept  = req_valid && (state == S_IDLE);
  assign capture = ((state == S_REQ) && bus_addr_ok && bus_data_ok) ||
                   ((state == S_WAIT) && bus_data_ok);

`ifdef UNCACHE_POSTED_STORE_EN
  logic post_pulse;
  logic posted_q;

  // Track a posted store: early completion pulse, then silent background finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_pulse <= 1'b0;
      posted_q   <= 1'b0;
    end else begin
      post_pulse <= accept && req_wen;
      if (accept) begin
        posted_q <= req_wen;
      end else if (state == S_DONE) begin
        posted_q <= 1'b0;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch request fields on accept; capture load data on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_wen   <= 1'b0;
      l_size  <= SZ_B;
      l_wstrb <= '0;
      l_paddr <= '0;
      l_wdata <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        l_wen   <= req_wen;
        l_size  <= req_size;
        l_wstrb <= req_wstrb;
        l_paddr <= req_paddr;
        l_wdata <= req_wdata;
      end
      if (capture && !l_wen) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    bus_req    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) state_nxt = S_REQ;
      end
      S_REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_addr_ok) state_nxt = bus_data_ok ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_data_ok) state_nxt = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef UNCACHE_POSTED_STORE_EN
    // A posted store already answered the pipeline; only a new request waits
    if (posted_q) begin
      resp_valid = post_pulse;
      if ((state == S_REQ) || (state == S_WAIT)) begin
        stall = req_valid && !post_pulse;
      end
    end
`endif
  end

  assign bus_wr     = l_wen;
  assign bus_size   = l_size;
  assign bus_addr   = l_paddr;
  assign bus_wstrb  = l_wstrb;
  assign bus_wdata  = l_wdata;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_uncache_dport.sv
// Scoreboard bench for uncache_dport: random loads/stores against a random-latency bus model.
// Inputs change 1 ns after an edge; DUT outputs are sampled on the falling edge.
// Covers directed reset, spurious data_ok, reset in WAIT and the canonical load example.
module tb_uncache_dport;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_wen;
  logic [1:0]    req_size;
  logic [3:0]    req_wstrb;
  logic [AW-1:0] req_paddr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, resp_valid, stall;
  logic [DW-1:0] resp_rdata;
  logic          bus_req, bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_wstrb;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok, bus_data_ok;
  logic [DW-1:0] bus_rdata;

  // bus inputs come from the random responder or from directed code
  logic          auto_bus;
  logic          r_addr_ok, r_data_ok, m_addr_ok, m_data_ok;
  logic [DW-1:0] r_rdata, m_rdata;
  assign bus_addr_ok = auto_bus ? r_addr_ok : m_addr_ok;
  assign bus_data_ok = auto_bus ? r_data_ok : m_data_ok;
  assign bus_rdata   = auto_bus ? r_rdata   : m_rdata;

  uncache_dport #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wen(req_wen), .req_size(req_size),
    .req_wstrb(req_wstrb), .req_paddr(req_paddr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .stall(stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic          wen;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] paddr;
    logic [DW-1:0] wdata;
    bit            posted;
  } req_t;

  typedef struct {
    logic [DW-1:0] rdata;
    int            cyc;
  } rsp_t;

  req_t          req_q[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] last_rdata = '0;
  bit            busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_bus(input req_t e);
    chk("bus_addr",  bus_addr,  e.paddr);
    chk("bus_wr",    bus_wr,    e.wen);
    chk("bus_size",  bus_size,  e.size);
    chk("bus_wstrb", bus_wstrb, e.wstrb);
    chk("bus_wdata", bus_wdata, e.wdata);
  endtask

  // Monitor: one outstanding transaction at most; pops expected responses
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
        continue;
      end
`ifndef UNCACHE_POSTED_STORE_EN
      chk("stall", stall, busy ? !resp_valid : req_valid);
      chk("req_ready", req_ready, !busy);
`endif
      if (resp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_resp_valid", 1, 0);
        end else begin
          r = rsp_q.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_cycle", cyc, r.cyc);
        end
        busy = 1'b0;
      end
      if (req_valid && req_ready) busy = 1'b1;
    end
  end

  // Random-latency SRAM-like slave; predicts the completion cycle and data
  initial begin
    req_t          e;
    int            da, dd, m;
    logic [DW-1:0] rd;
    r_addr_ok = 1'b0;
    r_data_ok = 1'b0;
    r_rdata   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rdata = '0;
        continue;
      end
      if (!auto_bus || !bus_req) continue;
      if (req_q.size() == 0) begin
        chk("unexpected_bus_req", 1, 0);
        continue;
      end
      e = req_q.pop_front();
      chk_bus(e);
      da = $urandom_range(0, 5);
      dd = $urandom_range(0, 3);
      for (int i = 0; i < da; i++) begin
        #1;
        r_addr_ok = 1'b0;
        r_data_ok = ($urandom_range(0, 3) == 0);  // must be ignored before addr_ok
        r_rdata   = $urandom;
        @(negedge clk);
        chk("bus_req_held", bus_req, 1);
        chk_bus(e);
      end
      #1;
      m         = cyc;
      rd        = $urandom;
      r_addr_ok = 1'b1;
      r_data_ok = (dd == 0);
      r_rdata   = rd;
      if (dd == 0) begin
        if (!e.posted) rsp_q.push_back('{e.wen ? last_rdata : rd, m + 1});
        if (!e.wen) last_rdata = rd;
      end
      @(negedge clk);
      chk("bus_req_drop", bus_req, 0);
      if (dd == 0) begin
        #1;
        r_addr_ok = 1'b0;
        r_data_ok = 1'b0;
      end else begin
        for (int j = 1; j <= dd; j++) begin
          if (j > 1) begin
            @(negedge clk);
            chk("bus_req_quiet", bus_req, 0);
          end
          #1;
          rd        = $urandom;
          r_addr_ok = 1'b0;
          r_data_ok = (j == dd);
          r_rdata   = rd;
        end
        if (!e.posted) rsp_q.push_back('{e.wen ? last_rdata : rd, m + dd + 1});
        if (!e.wen) last_rdata = rd;
        @(negedge clk);
        #1;
        r_data_ok = 1'b0;
      end
    end
  end

  // Present one request and hold it until accepted
  task automatic issue(input req_t e);
    bit got;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wen   = e.wen;
    req_size  = e.size;
    req_wstrb = e.wstrb;
    req_paddr = e.paddr;
    req_wdata = e.wdata;
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
    end else begin
      req_q.push_back(e);
      if (e.posted) rsp_q.push_back('{last_rdata, cyc + 1});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    req_t e;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_size  = 2'b00;
    req_wstrb = 4'h0;
    req_paddr = '0;
    req_wdata = '0;
    auto_bus  = 1'b0;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_rdata   = '0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_bus_req",    bus_req,    0);
    chk("rst_bus_wr",     bus_wr,     0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_bus_addr",   bus_addr,   0);
    chk("rst_stall",      stall,      0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);

    // spurious data_ok in IDLE
    @(posedge clk);
    #1;
    m_data_ok = 1'b1;
    m_rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    chk("spur_resp_valid", resp_valid, 0);
    chk("spur_bus_req",    bus_req,    0);
    @(posedge clk);
    #1 m_data_ok = 1'b0;
    @(negedge clk);
    chk("spur_resp_valid2", resp_valid, 0);
    chk("spur_req_ready",   req_ready,  1);
    chk("spur_resp_rdata",  resp_rdata, 0);

    // canonical load: addr_ok one cycle after accept, data_ok the next
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_size  = 2'b10;
    req_wstrb = 4'hF;
    req_paddr = 32'h1FC0_0010;
    @(negedge clk);
    chk("ex_accept", req_ready, 1);
    rsp_q.push_back('{32'hDEAD_BEEF, cyc + 3});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    m_addr_ok = 1'b1;
    @(negedge clk);
    chk("ex_bus_req",  bus_req,  1);
    chk("ex_bus_addr", bus_addr, 32'h1FC0_0010);
    chk("ex_bus_size", bus_size, 2'b10);
    @(posedge clk);
    #1;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b1;
    m_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ex_bus_req_drop", bus_req, 0);
    @(posedge clk);
    #1 m_data_ok = 1'b0;
    repeat (2) @(negedge clk);
    chk("ex_rdata_hold", resp_rdata, 32'hDEAD_BEEF);

    // reset while in WAIT, then a late data_ok
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_paddr = 32'hBFC0_0100;
    @(negedge clk);
    chk("rw_accept", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    m_addr_ok = 1'b1;
    @(negedge clk);
    chk("rw_bus_req", bus_req, 1);
    @(posedge clk);
    #1 m_addr_ok = 1'b0;
    @(negedge clk);
    chk("rw_wait_bus_req", bus_req, 0);
    chk("rw_wait_stall",   stall,   1);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_data_ok = 1'b1;
    m_rdata   = 32'h1234_5678;
    @(negedge clk);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_req_ready",  req_ready,  1);
    chk("rw_resp_rdata", resp_rdata, 0);
    @(posedge clk);
    #1 m_data_ok = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rw_no_late_resp", resp_valid, 0);
    end

    // randomized traffic against the bus model
    auto_bus = 1'b1;
    for (int n = 0; n < 150; n++) begin
      e.wen   = $urandom_range(0, 1);
      e.size  = 2'($urandom_range(0, 2));
      e.wstrb = 4'($urandom);
      e.paddr = $urandom;
      e.wdata = $urandom;
`ifdef UNCACHE_POSTED_STORE_EN
      e.posted = e.wen;
`else
      e.posted = 1'b0;
`endif
      issue(e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // drain
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && req_q.size() == 0) break;
    end
    chk("drain_rsp_q", rsp_q.size(), 0);
    chk("drain_req_q", req_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
